// File: rtl/md_seq_if.sv
// Execute-stage multiply/divide bus: op request, operands, flush, and
// stall/done/result back to the pipeline.
interface md_seq_if #(
    parameter int XLEN = 32
);
    logic            StartE;
    logic [2:0]      MdOpE;
    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic            FlushE;
    logic            MdStallE;
    logic            MdDoneE;
    logic [XLEN-1:0] MdResultE;

    modport master (
        output StartE, MdOpE, SrcAE, SrcBE, FlushE,
        input  MdStallE, MdDoneE, MdResultE
    );

    modport slave (
        input  StartE, MdOpE, SrcAE, SrcBE, FlushE,
        output MdStallE, MdDoneE, MdResultE
    );
endinterface

// File: rtl/md_seq.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and
// restoring divide on magnitudes, with sign fix-up on completion.
module md_seq #(
    parameter int XLEN = 32
) (
    input logic     clk,
    input logic     rst,
    md_seq_if.slave bus
);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t            state;
    logic [5:0]        cnt;
    logic [2:0]        op;
    logic              neg_q;
    logic              neg_r;
    logic [XLEN-1:0]   b_q;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   res_q;
    logic [2*XLEN-1:0] mcand;
    logic [2*XLEN-1:0] prod;
    logic              done_q;

    logic            a_sgn;
    logic            b_sgn;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div0;
    logic            ovf;
    logic [XLEN-1:0] spec_res;

    always_comb begin
        a_sgn = bus.MdOpE inside {3'd1, 3'd2, 3'd4, 3'd6};
        b_sgn = bus.MdOpE inside {3'd1, 3'd4, 3'd6};
        a_neg = a_sgn & bus.SrcAE[XLEN-1];
        b_neg = b_sgn & bus.SrcBE[XLEN-1];
        a_mag = a_neg ? -bus.SrcAE : bus.SrcAE;
        b_mag = b_neg ? -bus.SrcBE : bus.SrcBE;
        div0  = bus.MdOpE[2] & (bus.SrcBE == '0);
        ovf   = bus.MdOpE[2] & ~bus.MdOpE[0]
              & (bus.SrcAE == MIN) & (bus.SrcBE == '1);
        // REM/REMU select the remainder, DIV/DIVU the quotient
        if (div0)
            spec_res = bus.MdOpE[1] ? bus.SrcAE : '1;
        else
            spec_res = bus.MdOpE[1] ? '0 : MIN;
    end

    logic [2*XLEN-1:0] prod_nx;
    logic [2*XLEN-1:0] mul_fin;
    logic [XLEN-1:0]   mul_res;

    always_comb begin
        prod_nx = prod + (b_q[0] ? mcand : '0);
        mul_fin = neg_q ? -prod_nx : prod_nx;
        mul_res = (op[1:0] == 2'd0) ? mul_fin[XLEN-1:0]
                                    : mul_fin[2*XLEN-1:XLEN];
    end

    logic [XLEN:0]   rsh;
    logic [XLEN:0]   diff;
    logic            ge;
    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] quo_nx;
    logic [XLEN-1:0] q_fin;
    logic [XLEN-1:0] r_fin;
    logic [XLEN-1:0] div_res;

    always_comb begin
        rsh     = {rem, quo[XLEN-1]};
        diff    = rsh - {1'b0, b_q};
        ge      = ~diff[XLEN];
        rem_nx  = ge ? diff[XLEN-1:0] : rsh[XLEN-1:0];
        quo_nx  = {quo[XLEN-2:0], ge};
        q_fin   = neg_q ? -quo_nx : quo_nx;
        r_fin   = neg_r ? -rem_nx : rem_nx;
        div_res = op[1] ? r_fin : q_fin;
    end

    assign bus.MdStallE  = bus.StartE & ~bus.FlushE & (state != DONE);
    assign bus.MdDoneE   = done_q & ~bus.FlushE;
    assign bus.MdResultE = bus.MdDoneE ? res_q : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            op     <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_q    <= '0;
            quo    <= '0;
            rem    <= '0;
            res_q  <= '0;
            mcand  <= '0;
            prod   <= '0;
            done_q <= 1'b0;
        end else if (bus.FlushE) begin
            state  <= IDLE;
            cnt    <= '0;
            res_q  <= '0;
            done_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.StartE) begin
                        op    <= bus.MdOpE;
                        cnt   <= '0;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        b_q   <= b_mag;
                        quo   <= a_mag;
                        rem   <= '0;
                        prod  <= '0;
                        mcand <= {{XLEN{1'b0}}, a_mag};
                        if (div0 | ovf) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                            res_q  <= spec_res;
                        end else begin
                            state <= bus.MdOpE[2] ? DIV : MUL;
                        end
                    end
                end
                MUL: begin
                    prod  <= prod_nx;
                    mcand <= mcand << 1;
                    b_q   <= b_q >> 1;
                    if (cnt == 6'd31) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                        res_q  <= mul_res;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                DIV: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    if (cnt == 6'd31) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                        res_q  <= div_res;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    res_q  <= '0;
                end
                default: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
